// File: rtl/register_file_bypass.sv
// 32 x 64-bit integer register file: two combinational read ports, one synchronous
// write port, hardwired-zero register and write-through bypass onto BusA/BusB.
module register_file_bypass #(
  parameter int WIDTH    = 64,
  parameter int AWIDTH   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [AWIDTH-1:0] RA,
  input  logic [AWIDTH-1:0] RB,
  input  logic [AWIDTH-1:0] RW,
  input  logic [WIDTH-1:0]  BusW,
  input  logic              RegWr,
  output logic [WIDTH-1:0]  BusA,
  output logic [WIDTH-1:0]  BusB
);

  localparam int               NREGS     = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] ZERO_ADDR = AWIDTH'(ZERO_REG);

  logic [WIDTH-1:0] regs [NREGS];

  logic write_en;
  assign write_en = RegWr && (RW != ZERO_ADDR);

  // NOTE: the whole array is cleared synchronously so every read is defined after the
  // first reset edge; this costs a reset mux per bit instead of a plain RAM macro.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        // NOTE: non-blocking assignment keeps all register updates on the same edge.
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[RW] <= BusW;
    end
  end

  // Bypass uses write_en, so a write aimed at the zero register never leaks BusW.
  always_comb begin
    // NOTE: defaults first so every path assigns both buses and no latch is inferred.
    BusA = '0;
    BusB = '0;
    if (!Reset) begin
      if (RA != ZERO_ADDR) begin
        BusA = (write_en && (RW == RA)) ? BusW : regs[RA];
      end
      if (RB != ZERO_ADDR) begin
        BusB = (write_en && (RW == RB)) ? BusW : regs[RB];
      end
    end
  end

endmodule

// File: tb/tb_register_file_bypass.sv
// Directed self-checking bench for register_file_bypass: reset, write/read, bypass,
// zero register, mid-operation reset and a full sweep.
module tb_register_file_bypass;

  localparam int WIDTH  = 64;
  localparam int AWIDTH = 5;

  logic              Clk;
  logic              Reset;
  logic [AWIDTH-1:0] RA, RB, RW;
  logic [WIDTH-1:0]  BusW;
  logic              RegWr;
  logic [WIDTH-1:0]  BusA, BusB;

  int n_checks = 0;
  int n_fail   = 0;

  register_file_bypass #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .ZERO_REG(31)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .RA    (RA),
    .RB    (RB),
    .RW    (RW),
    .BusW  (BusW),
    .RegWr (RegWr),
    .BusA  (BusA),
    .BusB  (BusB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] actual,
                       input logic [WIDTH-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; writes take effect on the next rising edge.
  task automatic write_reg(input logic [AWIDTH-1:0] addr, input logic [WIDTH-1:0] data);
    @(negedge Clk);
    Reset = 1'b0; RegWr = 1'b1; RW = addr; BusW = data;
    @(posedge Clk);
  endtask

  task automatic read_check(input string tag, input logic [AWIDTH-1:0] ra,
                            input logic [AWIDTH-1:0] rb,
                            input logic [WIDTH-1:0] exp_a, input logic [WIDTH-1:0] exp_b);
    @(negedge Clk);
    Reset = 1'b0; RegWr = 1'b0; RA = ra; RB = rb;
    #1;
    check({tag, "_a"}, BusA, exp_a);
    check({tag, "_b"}, BusB, exp_b);
  endtask

  // One reset cycle with a competing write to X5 that must be dropped and not bypassed.
  task automatic reset_cycle(input string tag);
    @(negedge Clk);
    Reset = 1'b1; RegWr = 1'b1; RW = 5'd5; BusW = 64'hDEAD; RA = 5'd5; RB = 5'd5;
    #1;
    check({tag, "_during_a"}, BusA, 64'h0);
    check({tag, "_during_b"}, BusB, 64'h0);
    @(posedge Clk);
  endtask

  logic [WIDTH-1:0] val_i, val_j;

  initial begin
    Reset = 1'b0; RegWr = 1'b0; RA = '0; RB = '0; RW = '0; BusW = '0;

    // 1. Reset
    reset_cycle("rst");
    read_check("rst_after", 5'd5, 5'd0, 64'h0, 64'h0);

    // 2. Write then read
    write_reg(5'd3, 64'h0123_4567_89AB_CDEF);
    read_check("wr_x3", 5'd3, 5'd3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // 3. Bypass, with an unrelated read of X8 returning its stored value
    write_reg(5'd7, 64'h1);
    write_reg(5'd8, 64'h88);
    @(negedge Clk);
    RegWr = 1'b1; RW = 5'd7; BusW = 64'hFFFF_FFFF_FFFF_FFFF; RA = 5'd7; RB = 5'd8;
    #1;
    check("byp_a", BusA, 64'hFFFF_FFFF_FFFF_FFFF);
    check("byp_b", BusB, 64'h88);
    @(negedge Clk);
    RegWr = 1'b1; RW = 5'd8; BusW = 64'h1234; RA = 5'd8; RB = 5'd8;
    #1;
    check("byp_same_a", BusA, 64'h1234);
    check("byp_same_b", BusB, 64'h1234);
    @(negedge Clk);
    RegWr = 1'b0; RW = 5'd7; BusW = 64'hAAAA; RA = 5'd7; RB = 5'd8;
    #1;
    check("nobyp_a", BusA, 64'hFFFF_FFFF_FFFF_FFFF);
    check("nobyp_b", BusB, 64'h1234);
    read_check("byp_after", 5'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);

    // 4. Zero register
    @(negedge Clk);
    RegWr = 1'b1; RW = 5'd31; BusW = 64'h55; RA = 5'd31; RB = 5'd3;
    #1;
    check("xzr_same_a", BusA, 64'h0);
    check("xzr_same_b", BusB, 64'h0123_4567_89AB_CDEF);
    @(posedge Clk);
    read_check("xzr_after", 5'd31, 5'd31, 64'h0, 64'h0);

    // 5. Mid-operation reset
    for (int i = 1; i <= 4; i++) write_reg(AWIDTH'(i), 64'(i));
    read_check("mid_pre", 5'd1, 5'd4, 64'h1, 64'h4);
    reset_cycle("mid_rst");
    read_check("mid_x1x2", 5'd1, 5'd2, 64'h0, 64'h0);
    read_check("mid_x3x4", 5'd3, 5'd4, 64'h0, 64'h0);
    read_check("mid_x5x7", 5'd5, 5'd7, 64'h0, 64'h0);
    write_reg(5'd2, 64'h9);
    read_check("mid_x2", 5'd2, 5'd1, 64'h9, 64'h0);

    // 6. Sweep
    for (int i = 0; i <= 30; i++) write_reg(AWIDTH'(i), 64'(i) * 64'h0101_0101_0101_0101);
    for (int i = 0; i <= 30; i++) begin
      val_i = 64'(i) * 64'h0101_0101_0101_0101;
      val_j = 64'(30 - i) * 64'h0101_0101_0101_0101;
      read_check($sformatf("sweep_%0d", i), AWIDTH'(i), AWIDTH'(30 - i), val_i, val_j);
    end
    read_check("sweep_x31", 5'd31, 5'd31, 64'h0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
